ssd_scan_driver: RTL

- Parametrised multiplexed seven-segment driver that succeeds the fixed 4-digit hex counter display.
- Takes a binary value and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes NUM_DIGITS digits, with optional leading-zero blanking, per-digit decimal points and overflow indication.
- Sits beside the VGA path in the top level and displays the game score (e.g. zombies killed).

---
 rtl/ssd_scan_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: sequential binary-to-BCD converter feeding a multiplexed seven-segment scan.
module ssd_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blank_en,
    input  logic [NUM_DIGITS-1:0] dp_en,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} stateType;

    stateType              state, nextState;
    logic [VALUE_W-1:0]    shiftReg;
    logic [BCD_W-1:0]      bcdAcc, bcdAdj, bcdNext, dispBcd;
    logic [CNT_W-1:0]      bitCnt;
    logic                  ovfPending, overflow;
    logic                  busyNext, doneNext;
    logic [DIV_W-1:0]      divCnt;
    logic [IDX_W-1:0]      scanIdx;
    logic [3:0]            curDigit;
    logic                  leadZero, blankCur;
    logic [6:0]            segNext;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nextState;

    // A load in any state restarts the conversion, so only the last value is committed.
    always_comb
        nextState = load ? CONVERT :
                    (state == CONVERT && bitCnt == CNT_W'(1)) ? COMMIT :
                    state == COMMIT ? IDLE : state;

    always_comb begin
        busyNext = nextState == CONVERT;
        doneNext = state == COMMIT && nextState == IDLE;
    end

    always_comb begin
        bcdAdj = bcdAcc;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] >= 4'd5 ? bcdAcc[4*i +: 4] + 4'd3 : bcdAcc[4*i +: 4];
        bcdNext = (bcdAdj << 1) | BCD_W'(shiftReg[VALUE_W-1]);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            shiftReg   <= '0;
            bcdAcc     <= '0;
            bitCnt     <= '0;
            ovfPending <= 1'b0;
            dispBcd    <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= busyNext;
            done <= doneNext;
            if (load) begin
                shiftReg   <= value;
                bcdAcc     <= '0;
                bitCnt     <= CNT_W'(VALUE_W);
                ovfPending <= 64'(value) > MAX_VAL;
            end else if (state == CONVERT) begin
                shiftReg <= shiftReg << 1;
                bcdAcc   <= bcdNext;
                bitCnt   <= bitCnt - CNT_W'(1);
            end
            if (doneNext) begin
                dispBcd  <= bcdAcc;
                overflow <= ovfPending;
            end
        end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        curDigit = dispBcd[{scanIdx, 2'b00} +: 4];
        leadZero = (dispBcd >> {scanIdx, 2'b00}) == '0;
        blankCur = blank_en && !overflow && scanIdx != '0 && leadZero;
        segNext  = overflow ? 7'b1111110 : blankCur ? 7'h7F : decode(curDigit);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            divCnt  <= '0;
            scanIdx <= '0;
            anode   <= '1;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            divCnt <= divCnt == DIV_W'(REFRESH_DIV - 1) ? '0 : divCnt + DIV_W'(1);
            if (divCnt == DIV_W'(REFRESH_DIV - 1))
                scanIdx <= scanIdx == IDX_W'(NUM_DIGITS - 1) ? '0 : scanIdx + IDX_W'(1);
            anode <= ~(NUM_DIGITS'(1) << scanIdx);
            seg   <= segNext;
            dp    <= ~dp_en[scanIdx];
        end
endmodule
